// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, FSM state type, stack-pointer select encodings
// and the per-step control decode used by ctrl_sequencer.
package ctrl_pkg;

  localparam int STEP_W = 2;
  typedef logic [STEP_W-1:0] step_t;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_MOV    = 4'd1;
  localparam logic [3:0] OP_LDPC   = 4'd2;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_PUSH   = 4'd7;
  localparam logic [3:0] OP_POP    = 4'd8;
  localparam logic [3:0] OP_CALL   = 4'd9;
  localparam logic [3:0] OP_RET    = 4'd10;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC} fsm_t;

  // Scalar controls plus the enables that feed the register one-hot decoders.
  typedef struct packed {
    logic       gin;
    logic       gout;
    logic       a_in;
    logic       addsub;
    logic       xorctrl;
    logic       pcin;
    logic       pcout;
    logic       pc_enable;
    logic       ctrl_out;
    logic       ram_addr_sel;
    logic       ram_out_ctrl;
    logic       wr_enable;
    logic       instr_enable;
    logic [1:0] sp_sel;
    logic       retire;
    logic       illegal;
    logic       rx_in;
    logic       rx_out;
    logic       ry_in;
    logic       ry_out;
    logic       sp_in;
  } ctrl_t;

  // Index of the final execute step; undefined opcodes finish in step 0.
  function automatic step_t last_step(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_XOR, OP_PUSH, OP_POP: return step_t'(2);
      OP_CALL:                                 return step_t'(3);
      OP_RET:                                  return step_t'(1);
      default:                                 return step_t'(0);
    endcase
  endfunction

  // Steps that touch RAM and therefore may stall on mem_ready.
  function automatic logic is_mem_step(input logic [3:0] op, input step_t step);
    return ((op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET))
           && (step == step_t'(1));
  endfunction

  // Moore decode of {state, step, opcode} into the control word.
  function automatic ctrl_t ctrl_decode(input fsm_t state, input step_t step, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (state)
      ST_FETCH: begin
        c.ram_out_ctrl = 1'b1;
        c.instr_enable = 1'b1;
      end
      ST_EXEC: begin
        c.retire = (step == last_step(op));
        case (op)
          OP_LOAD:   if (step == 2'd0) begin c.ctrl_out = 1'b1; c.rx_in = 1'b1; c.pc_enable = 1'b1; end
          OP_MOV:    if (step == 2'd0) begin c.ry_out = 1'b1; c.rx_in = 1'b1; c.pc_enable = 1'b1; end
          OP_LDPC:   if (step == 2'd0) begin c.pcout = 1'b1; c.rx_in = 1'b1; c.pc_enable = 1'b1; end
          OP_BRANCH: if (step == 2'd0) begin c.rx_out = 1'b1; c.pcin = 1'b1; c.pc_enable = 1'b1; end
          OP_SUB, OP_ADD, OP_XOR: begin
            case (step)
              2'd0: begin c.rx_out = 1'b1; c.a_in = 1'b1; end
              2'd1: begin
                c.ry_out  = 1'b1;
                c.gin     = 1'b1;
                c.addsub  = (op == OP_SUB);
                c.xorctrl = (op == OP_XOR);
              end
              2'd2: begin c.gout = 1'b1; c.rx_in = 1'b1; c.pc_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_PUSH: begin
            case (step)
              2'd0: c.ram_addr_sel = 1'b1;
              2'd1: begin c.rx_out = 1'b1; c.ram_addr_sel = 1'b1; c.wr_enable = 1'b1; end
              2'd2: begin c.sp_sel = SP_DEC; c.sp_in = 1'b1; c.pc_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_POP: begin
            case (step)
              2'd0: begin c.sp_sel = SP_INC; c.sp_in = 1'b1; end
              2'd1: begin c.ram_addr_sel = 1'b1; c.ram_out_ctrl = 1'b1; c.rx_in = 1'b1; end
              2'd2: c.pc_enable = 1'b1;
              default: ;
            endcase
          end
          OP_CALL: begin
            case (step)
              2'd0: c.pc_enable = 1'b1;
              2'd1: begin c.pcout = 1'b1; c.ram_addr_sel = 1'b1; c.wr_enable = 1'b1; end
              2'd2: begin c.sp_sel = SP_DEC; c.sp_in = 1'b1; end
              2'd3: begin c.rx_out = 1'b1; c.pcin = 1'b1; c.pc_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_RET: begin
            case (step)
              2'd0: begin c.sp_sel = SP_INC; c.sp_in = 1'b1; end
              2'd1: begin c.ram_addr_sel = 1'b1; c.ram_out_ctrl = 1'b1; c.pcin = 1'b1; c.pc_enable = 1'b1; end
              default: ;
            endcase
          end
          default: if (step == 2'd0) begin c.pc_enable = 1'b1; c.illegal = 1'b1; end
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction/handshake inputs and datapath control
// outputs of the sequencer. master = sequencer side, slave = datapath side.
interface ctrl_sequencer_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
);
  logic                run;
  logic [DATA_W-1:0]   instr;
  logic                mem_ready;
  logic [NUM_REGS-1:0] rin;
  logic [NUM_REGS-1:0] rout;
  logic                gin, gout, a_in, addsub, xorctrl;
  logic                pcin, pcout, pc_enable;
  logic                ctrl_out, ram_addr_sel;
  logic                ram_out_ctrl, wr_enable, instr_enable;
  logic [1:0]          sp_sel;
  logic                retire, illegal, busy;

  modport master (
    input  run, instr, mem_ready,
    output rin, rout, gin, gout, a_in, addsub, xorctrl, pcin, pcout, pc_enable,
           ctrl_out, ram_addr_sel, ram_out_ctrl, wr_enable, instr_enable,
           sp_sel, retire, illegal, busy
  );

  modport slave (
    output run, instr, mem_ready,
    input  rin, rout, gin, gout, a_in, addsub, xorctrl, pcin, pcout, pc_enable,
           ctrl_out, ram_addr_sel, ram_out_ctrl, wr_enable, instr_enable,
           sp_sel, retire, illegal, busy
  );
endinterface

// File: rtl/reg_onehot_decode.sv
// reg_onehot_decode: register index to one-hot enable; indices beyond
// NUM_REGS produce no enable at all.
module reg_onehot_decode #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4
) (
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic                 i_en,
  output logic [NUM_REGS-1:0]  o_onehot
);

  // Compare against every legal register number; out-of-range indices match none.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_onehot[k] = i_en && (i_idx == REG_IDX_W'(k));
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode/execute micro-sequencer for the 16-bit CPU.
// Optional feature macro CTRL_MEM_WAIT_EN: when defined, FETCH and RAM steps
// stall on mem_ready; otherwise every memory step takes one cycle.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int SP_REG    = 15
) (
  input logic         clk,
  input logic         reset,
  ctrl_sequencer_if.master bus
);

  localparam logic [NUM_REGS-1:0] SP_MASK =
    (SP_REG < NUM_REGS) ? (NUM_REGS'(1) << SP_REG) : '0;

  logic [3:0]           w_instr_op;
  logic [REG_IDX_W-1:0] w_instr_rx, w_instr_ry;
  logic                 w_mem_ok;
  logic                 w_unused_bits;

  fsm_t                 r_state, w_state;
  step_t                r_step, w_step;
  logic [3:0]           r_op, w_op;
  logic [REG_IDX_W-1:0] r_rx, w_rx, r_ry, w_ry;
  ctrl_t                r_ctrl, w_ctrl;
  logic [NUM_REGS-1:0]  r_rin, r_rout, w_rin, w_rout;
  logic [NUM_REGS-1:0]  w_rx_in_oh, w_rx_out_oh, w_ry_in_oh, w_ry_out_oh;

  assign w_instr_op = bus.instr[DATA_W-1 -: 4];
  assign w_instr_rx = bus.instr[DATA_W-5 -: REG_IDX_W];
  assign w_instr_ry = bus.instr[DATA_W-5-REG_IDX_W -: REG_IDX_W];

  // Instruction bits below the ry field (and mem_ready in the no-wait build) are not decoded.
  assign w_unused_bits = ^{bus.instr, bus.mem_ready};

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ok = bus.mem_ready;
`else
  assign w_mem_ok = 1'b1;
`endif

  // Next-state logic: a dropped run only takes effect on the last execute step.
  always_comb begin
    w_state = r_state;
    w_step  = r_step;
    w_op    = r_op;
    w_rx    = r_rx;
    w_ry    = r_ry;
    case (r_state)
      ST_IDLE:  if (bus.run) w_state = ST_FETCH;
      ST_FETCH: if (w_mem_ok) w_state = ST_DECODE;
      ST_DECODE: begin
        w_op    = w_instr_op;
        w_rx    = w_instr_rx;
        w_ry    = w_instr_ry;
        w_state = ST_EXEC;
        w_step  = '0;
      end
      ST_EXEC: begin
        if (!is_mem_step(r_op, r_step) || w_mem_ok) begin
          if (r_step == last_step(r_op)) begin
            w_state = bus.run ? ST_FETCH : ST_IDLE;
            w_step  = '0;
          end else begin
            w_step = r_step + step_t'(1);
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign w_ctrl = ctrl_decode(w_state, w_step, w_op);

  reg_onehot_decode #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_rx_in (
    .i_idx(w_rx), .i_en(w_ctrl.rx_in), .o_onehot(w_rx_in_oh));
  reg_onehot_decode #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_rx_out (
    .i_idx(w_rx), .i_en(w_ctrl.rx_out), .o_onehot(w_rx_out_oh));
  reg_onehot_decode #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_ry_in (
    .i_idx(w_ry), .i_en(w_ctrl.ry_in), .o_onehot(w_ry_in_oh));
  reg_onehot_decode #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_ry_out (
    .i_idx(w_ry), .i_en(w_ctrl.ry_out), .o_onehot(w_ry_out_oh));

  assign w_rin  = w_rx_in_oh | w_ry_in_oh | (w_ctrl.sp_in ? SP_MASK : '0);
  assign w_rout = w_rx_out_oh | w_ry_out_oh;

  // State register; outputs are the decode of the next state so they are registered yet still Moore.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_op    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_ctrl  <= '0;
      r_rin   <= '0;
      r_rout  <= '0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_op    <= w_op;
      r_rx    <= w_rx;
      r_ry    <= w_ry;
      r_ctrl  <= w_ctrl;
      r_rin   <= w_rin;
      r_rout  <= w_rout;
    end
  end

  assign bus.rin          = r_rin;
  assign bus.rout         = r_rout;
  assign bus.gin          = r_ctrl.gin;
  assign bus.gout         = r_ctrl.gout;
  assign bus.a_in         = r_ctrl.a_in;
  assign bus.addsub       = r_ctrl.addsub;
  assign bus.xorctrl      = r_ctrl.xorctrl;
  assign bus.pcin         = r_ctrl.pcin;
  assign bus.pcout        = r_ctrl.pcout;
  assign bus.pc_enable    = r_ctrl.pc_enable;
  assign bus.ctrl_out     = r_ctrl.ctrl_out;
  assign bus.ram_addr_sel = r_ctrl.ram_addr_sel;
  assign bus.ram_out_ctrl = r_ctrl.ram_out_ctrl;
  assign bus.wr_enable    = r_ctrl.wr_enable;
  assign bus.instr_enable = r_ctrl.instr_enable;
  assign bus.sp_sel       = r_ctrl.sp_sel;
  assign bus.retire       = r_ctrl.retire;
  assign bus.illegal      = r_ctrl.illegal;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench for ctrl_sequencer. The stimulus side
// expands each instruction into its expected per-cycle control vectors and
// queues them; a monitor compares every cycle and checks each retire pulse.
module tb_ctrl_sequencer;

  localparam int NR = 16;
`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NR-1:0] rin;
    logic [NR-1:0] rout;
    logic gin, gout, a_in, addsub, xorctrl, pcin, pcout, pc_enable;
    logic ctrl_out, ram_addr_sel, ram_out_ctrl, wr_enable, instr_enable;
    logic [1:0] sp_sel;
    logic retire, illegal, busy;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_sequencer_if #(.DATA_W(16), .NUM_REGS(NR)) bus ();

  ctrl_sequencer #(.DATA_W(16), .NUM_REGS(NR), .REG_IDX_W(4), .SP_REG(15)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  outs_t expQ[$];
  string tagQ[$];
  bit    retQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  int    cycle = 0;
  outs_t act, expV;
  string tagV;
  bit    retExp;

  // Reference model: expected controls straight from the instruction step table.
  function automatic outs_t idleOuts();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t fetchOuts();
    outs_t o = '0;
    o.ram_out_ctrl = 1'b1; o.instr_enable = 1'b1; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t decodeOuts();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic int numSteps(input logic [3:0] op);
    if (op <= 3) return 1;
    if (op <= 8) return 3;
    if (op == 9) return 4;
    if (op == 10) return 2;
    return 1;
  endfunction

  function automatic bit isMemStep(input logic [3:0] op, input int s);
    return (op >= 7 && op <= 10) && (s == 1);
  endfunction

  function automatic outs_t execOuts(input logic [3:0] op, input logic [3:0] rx,
                                     input logic [3:0] ry, input int s);
    outs_t o = '0;
    logic [NR-1:0] mx, my, sp;
    mx = NR'(1) << rx;
    my = NR'(1) << ry;
    sp = NR'(1) << 15;
    o.busy   = 1'b1;
    o.retire = (s == numSteps(op) - 1);
    case (op)
      4'd0: begin o.ctrl_out = 1; o.rin = mx; o.pc_enable = 1; end
      4'd1: begin o.rout = my; o.rin = mx; o.pc_enable = 1; end
      4'd2: begin o.pcout = 1; o.rin = mx; o.pc_enable = 1; end
      4'd3: begin o.rout = mx; o.pcin = 1; o.pc_enable = 1; end
      4'd4, 4'd5, 4'd6: begin
        if (s == 0) begin o.rout = mx; o.a_in = 1; end
        if (s == 1) begin o.rout = my; o.gin = 1; o.addsub = (op == 4); o.xorctrl = (op == 6); end
        if (s == 2) begin o.gout = 1; o.rin = mx; o.pc_enable = 1; end
      end
      4'd7: begin
        if (s == 0) o.ram_addr_sel = 1;
        if (s == 1) begin o.rout = mx; o.ram_addr_sel = 1; o.wr_enable = 1; end
        if (s == 2) begin o.sp_sel = 2'b10; o.rin = sp; o.pc_enable = 1; end
      end
      4'd8: begin
        if (s == 0) begin o.sp_sel = 2'b01; o.rin = sp; end
        if (s == 1) begin o.ram_addr_sel = 1; o.ram_out_ctrl = 1; o.rin = mx; end
        if (s == 2) o.pc_enable = 1;
      end
      4'd9: begin
        if (s == 0) o.pc_enable = 1;
        if (s == 1) begin o.pcout = 1; o.ram_addr_sel = 1; o.wr_enable = 1; end
        if (s == 2) begin o.sp_sel = 2'b10; o.rin = sp; end
        if (s == 3) begin o.rout = mx; o.pcin = 1; o.pc_enable = 1; end
      end
      4'd10: begin
        if (s == 0) begin o.sp_sel = 2'b01; o.rin = sp; end
        if (s == 1) begin o.ram_addr_sel = 1; o.ram_out_ctrl = 1; o.pcin = 1; o.pc_enable = 1; end
      end
      default: begin o.pc_enable = 1; o.illegal = 1; end
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic applyStimulus(input bit rst, input bit runV, input bit mr,
                               input logic [15:0] ins, input outs_t e, input string tag);
    @(negedge clk);
    reset         = rst;
    bus.run       = runV;
    bus.mem_ready = mr;
    bus.instr     = ins;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic startFromIdle(input logic [15:0] ins);
    applyStimulus(1'b0, 1'b1, 1'b1, ins, fetchOuts(), "enter-fetch");
  endtask

  // Entered with the DUT about to sit in FETCH; run follows runAfter from decode on.
  task automatic runInstr(input logic [15:0] ins, input int fstall, input int mstall, input bit runAfter);
    logic [3:0] op, rx, ry;
    int n, f, m;
    bit mr;
    outs_t nxt;
    op = ins[15:12]; rx = ins[11:8]; ry = ins[7:4];
    n  = numSteps(op);
    retQ.push_back(op >= 11);
    f = WAIT_EN ? fstall : 0;
    for (int i = 0; i < f; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, ins, fetchOuts(), "fetch-wait");
    applyStimulus(1'b0, 1'b1, (!WAIT_EN && fstall > 0) ? 1'b0 : 1'b1, ins, decodeOuts(), "decode");
    applyStimulus(1'b0, runAfter, 1'b1, ins, execOuts(op, rx, ry, 0), $sformatf("op%0d-s0", op));
    for (int s = 0; s < n; s++) begin
      if (isMemStep(op, s)) begin
        m = WAIT_EN ? mstall : 0;
        for (int i = 0; i < m; i++)
          applyStimulus(1'b0, runAfter, 1'b0, ins, execOuts(op, rx, ry, s), $sformatf("op%0d-s%0d-wait", op, s));
        mr = (!WAIT_EN && mstall > 0) ? 1'b0 : 1'b1;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      if (s == n - 1) nxt = runAfter ? fetchOuts() : idleOuts();
      else            nxt = execOuts(op, rx, ry, s + 1);
      applyStimulus(1'b0, runAfter, mr, ins, nxt,
                    (s == n - 1) ? $sformatf("op%0d-after", op) : $sformatf("op%0d-s%0d", op, s + 1));
    end
  endtask

  // Pop is abandoned by reset while its RAM step is stalled; DUT ends in IDLE.
  task automatic resetDuringPop(input logic [15:0] ins);
    logic [3:0] rx, ry;
    rx = ins[11:8]; ry = ins[7:4];
    applyStimulus(1'b0, 1'b1, 1'b1, ins, decodeOuts(), "pop-decode");
    applyStimulus(1'b0, 1'b1, 1'b1, ins, execOuts(4'd8, rx, ry, 0), "pop-s0");
    applyStimulus(1'b0, 1'b1, 1'b1, ins, execOuts(4'd8, rx, ry, 1), "pop-s1");
    applyStimulus(1'b1, 1'b1, 1'b0, ins, idleOuts(), "reset-mid-pop");
    applyStimulus(1'b0, 1'b0, 1'b1, ins, idleOuts(), "idle-after-reset");
  endtask

  // Monitor: compare the full control vector every cycle and check each retire.
  always @(posedge clk) begin
    #1;
    cycle++;
    act.rin = bus.rin;           act.rout = bus.rout;
    act.gin = bus.gin;           act.gout = bus.gout;
    act.a_in = bus.a_in;         act.addsub = bus.addsub;
    act.xorctrl = bus.xorctrl;   act.pcin = bus.pcin;
    act.pcout = bus.pcout;       act.pc_enable = bus.pc_enable;
    act.ctrl_out = bus.ctrl_out; act.ram_addr_sel = bus.ram_addr_sel;
    act.ram_out_ctrl = bus.ram_out_ctrl; act.wr_enable = bus.wr_enable;
    act.instr_enable = bus.instr_enable; act.sp_sel = bus.sp_sel;
    act.retire = bus.retire;     act.illegal = bus.illegal;
    act.busy = bus.busy;
    if (expQ.size() > 0) begin
      expV = expQ.pop_front();
      tagV = tagQ.pop_front();
      testsRun++;
      if (act !== expV) begin
        testsFailed++;
        $display("[TB] FAIL %s cycle %0d: got %h required %h", tagV, cycle, act, expV);
      end
    end
    if (bus.retire === 1'b1) begin
      testsRun++;
      if (retQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL retire cycle %0d: got retire=1 required no retire", cycle);
      end else begin
        retExp = retQ.pop_front();
        if (bus.illegal !== retExp) begin
          testsFailed++;
          $display("[TB] FAIL retire-illegal cycle %0d: got %b required %b", cycle, bus.illegal, retExp);
        end
      end
    end
  end

  initial begin
    logic [15:0] ins;
    bit idle;
    bit ra;
    reset = 1'b1; bus.run = 1'b0; bus.mem_ready = 1'b1; bus.instr = '0;
    $display("[TB] start, wait-state feature = %0d", WAIT_EN);

    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, idleOuts(), "reset");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0, idleOuts(), "reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, idleOuts(), "idle");

    startFromIdle(16'h5120);
    runInstr(16'h5120, 0, 0, 1'b1);
    runInstr(16'h4340, 1, 0, 1'b1);
    runInstr(16'h6340, 0, 0, 1'b1);
    runInstr(16'h7500, 0, 3, 1'b1);
    runInstr(16'h9200, 2, 1, 1'b1);
    runInstr(16'hC000, 0, 0, 1'b1);
    runInstr(16'h1330, 0, 0, 1'b1);
    runInstr(16'hA000, 0, 2, 1'b1);
    resetDuringPop(16'h8300);

    startFromIdle(16'h5120);
    runInstr(16'h5120, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, idleOuts(), "idle-after-drop");

    idle = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom);
      ra  = (k == 39) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (idle) begin
        repeat ($urandom_range(0, 2))
          applyStimulus(1'b0, 1'b0, 1'b1, ins, idleOuts(), "idle-gap");
        startFromIdle(ins);
      end
      runInstr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ra);
      idle = !ra;
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, idleOuts(), "idle-end");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, idleOuts(), "idle-end");
    @(negedge clk);
    @(negedge clk);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain-expected: got %0d left required 0", expQ.size());
    end
    testsRun++;
    if (retQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain-retire: got %0d missing retires required 0", retQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
